// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter funnelling NUM_REQ requesters onto one
// bus slave port. One transfer in flight at a time: IDLE -> BUSY -> DONE.
// Optional feature: define BUS_RR_ARBITER_TIMEOUT_EN to abort transfers whose
// slave has not answered within TIMEOUT busy cycles (m_err=1, rdata DEADBEEF).
module bus_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      m_req,
  input  logic [NUM_REQ-1:0]      m_rw,
  input  logic [NUM_REQ*32-1:0]   m_addr,
  input  logic [NUM_REQ*32-1:0]   m_wdata,
  output logic [NUM_REQ-1:0]      m_gnt,
  output logic [31:0]             m_rdata,
  output logic                    m_err,
  output logic                    bus_req,
  output logic                    bus_rw,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  input  logic                    bus_gnt,
  input  logic [31:0]             bus_rdata
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [OW-1:0] LAST = OW'(NUM_REQ - 1);
  localparam logic [31:0]   ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, state_nxt;
  logic [OW-1:0]             owner, last_owner, winner;
  logic                      any_req;
  logic                      tmo;
  logic [NUM_REQ-1:0][31:0]  addr_a, wdata_a;

  // Per-requester views of the flat address/data buses.
  assign addr_a  = m_addr;
  assign wdata_a = m_wdata;
  assign any_req = |m_req;

  // Round-robin pick: first requester found scanning from last_owner+1, wrapping.
  always_comb begin
    logic [OW:0]   sum;
    logic [OW-1:0] cand;
    logic          found;
    winner = last_owner;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_owner} + (OW+1)'(k);
      if (sum >= (OW+1)'(NUM_REQ)) sum = sum - (OW+1)'(NUM_REQ);
      cand = sum[OW-1:0];
      if (!found && m_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;

  // Busy-cycle counter: cleared when a transfer is launched, counts ungranted BUSY cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tcnt <= '0;
    else if (state == IDLE && any_req) tcnt <= '0;
    else if (state == BUSY && !bus_gnt) tcnt <= tcnt + 1'b1;
  end

  // Abort on the last allowed busy cycle; a grant in that same cycle wins.
  assign tmo = (state == BUSY) && !bus_gnt && (tcnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: launch on any request, finish on grant or abort, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)       state_nxt = BUSY;
      BUSY:    if (bus_gnt || tmo) state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the winner's request, drive the bus, return the completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      last_owner <= LAST;
      bus_req    <= 1'b0;
      bus_rw     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      m_gnt      <= '0;
      m_rdata    <= '0;
    end else begin
      m_gnt <= '0;
      case (state)
        IDLE: if (any_req) begin
          owner     <= winner;
          bus_req   <= 1'b1;
          bus_rw    <= m_rw[winner];
          bus_addr  <= addr_a[winner];
          bus_wdata <= wdata_a[winner];
        end
        BUSY: if (bus_gnt) begin
          m_rdata       <= bus_rdata;
          m_gnt[owner]  <= 1'b1;
          bus_req       <= 1'b0;
          last_owner    <= owner;
        end else if (tmo) begin
          m_rdata       <= ABORT_DATA;
          m_gnt[owner]  <= 1'b1;
          bus_req       <= 1'b0;
          last_owner    <= owner;
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
  logic err_q;

  // Error flag is a pulse aligned with m_gnt, set only for aborted transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= tmo;
  end

  assign m_err = err_q;
`else
  assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with a scoreboard of expected completions
// and a slave model that answers after a programmable number of busy cycles.
module tb_bus_rr_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_req = '0;
  logic [N-1:0]      m_rw = '0;
  logic [N-1:0][31:0] ma = '0;
  logic [N-1:0][31:0] mwd = '0;
  logic [N-1:0]      m_gnt;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic              bus_req, bus_rw;
  logic [31:0]       bus_addr, bus_wdata;
  logic              bus_gnt = 1'b0;
  logic [31:0]       bus_rdata = '0;

  bus_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_rw(m_rw), .m_addr(ma), .m_wdata(mwd),
    .m_gnt(m_gnt), .m_rdata(m_rdata), .m_err(m_err),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vecs = 0, errs = 0;
  int          cyc = 0, last_gnt = -1, busy_cnt = 0;
  // slave model controls
  int          swait = 0, scnt = 0;
  bit          sfixed = 0, spur = 0;
  logic [31:0] srd = '0;
  // monitor controls
  bit          hold = 0, chk_space = 0, chk_bus = 0;
  logic [31:0] eb_addr = '0, eb_wdata = '0;
  logic        eb_rw = 1'b0;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int o, input logic [31:0] rd, input logic e);
    exp_t x;
    x.owner = o; x.rd = rd; x.err = e;
    sb.push_back(x);
  endtask

  // One clock: sample after the edge, score completions, then drive the slave.
  task automatic tick();
    exp_t        e;
    logic [N-1:0] oh;
    @(posedge clk); #1;
    cyc++;
    if (m_gnt !== '0) begin
      if (sb.size() == 0) chk("unexpected_gnt", 32'(m_gnt), 32'h0);
      else begin
        e  = sb.pop_front();
        oh = '0; oh[e.owner] = 1'b1;
        chk("gnt_onehot", 32'(m_gnt), 32'(oh));
        chk("rdata", m_rdata, e.rd);
        chk("err", 32'(m_err), 32'(e.err));
        if (chk_space && last_gnt >= 0) chk("spacing", 32'(cyc - last_gnt), 32'd3);
        last_gnt = cyc;
        if (!hold) m_req[e.owner] = 1'b0;
        if (sb.size() == 0) m_req = '0;
      end
    end
    if (chk_bus && bus_req) begin
      chk("bus_addr", bus_addr, eb_addr);
      chk("bus_wdata", bus_wdata, eb_wdata);
      chk("bus_rw", 32'(bus_rw), 32'(eb_rw));
    end
    if (bus_req) begin
      busy_cnt++;
      bus_gnt   = (scnt == swait);
      bus_rdata = sfixed ? srd : slv_data(bus_addr);
      scnt++;
    end else begin
      bus_gnt   = spur;
      bus_rdata = 32'h0BAD_0BAD;
      scnt      = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin tick(); n++; end
    if (sb.size() != 0) begin
      chk("drain_budget", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    // reset values
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_rw", 32'(bus_rw), 0);
    chk("rst_m_gnt", 32'(m_gnt), 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_m_err", 32'(m_err), 0);
    rst = 1'b0;

    // single read, slave answers two cycles after bus_req
    ma[1] = 32'h100; m_rw[1] = 1'b0;
    swait = 2; sfixed = 1; srd = 32'hCAFE_0001;
    chk_bus = 1; eb_addr = 32'h100; eb_wdata = 32'h0; eb_rw = 1'b0;
    push(1, 32'hCAFE_0001, 1'b0);
    m_req = 4'b0010;
    tick();
    chk("req_latency", 32'(bus_req), 1);
    drain(20);
    chk_bus = 0;
    tick(); tick();
    chk("rdata_hold", m_rdata, 32'hCAFE_0001);

    // fairness under full load with zero-wait slave
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) ma[i] = 32'h1000 * (i + 1);
    swait = 0; sfixed = 0; hold = 1; chk_space = 1; last_gnt = -1;
    for (int i = 0; i < 2 * N; i++) push(i % N, slv_data(32'h1000 * ((i % N) + 1)), 1'b0);
    m_req = 4'b1111;
    drain(60);
    hold = 0; chk_space = 0;

    // write passthrough, bus fields stable across BUSY
    ma[2] = 32'h20; mwd[2] = 32'h5A5A_5A5A; m_rw[2] = 1'b1;
    swait = 3;
    chk_bus = 1; eb_addr = 32'h20; eb_wdata = 32'h5A5A_5A5A; eb_rw = 1'b1;
    busy_cnt = 0;
    push(2, slv_data(32'h20), 1'b0);
    m_req = 4'b0100;
    drain(20);
    chk("write_busy_cycles", 32'(busy_cnt), 32'd4);
    chk_bus = 0; m_rw[2] = 1'b0;

    // request dropped and another raised mid-transfer
    ma[0] = 32'h40; ma[3] = 32'h4444; swait = 2;
    push(0, slv_data(32'h40), 1'b0);
    push(3, slv_data(32'h4444), 1'b0);
    m_req = 4'b0001;
    tick();
    m_req = 4'b1000;
    tick();
    chk("inflight_addr", bus_addr, 32'h40);
    drain(30);

    // bus_gnt while idle is ignored
    spur = 1;
    tick(); tick(); tick();
    spur = 0;
    tick();
    chk("spur_bus_req", 32'(bus_req), 0);
    chk("spur_rdata", m_rdata, slv_data(32'h4444));

    // reset mid-transfer: no pulse, then priority restarts at requester 0
    swait = 1000;
    m_req = 4'b0001;
    tick(); tick();
    chk("pre_rst_busy", 32'(bus_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_bus_req", 32'(bus_req), 0);
    chk("rst_async_m_gnt", 32'(m_gnt), 0);
    m_req = 4'b1010; swait = 0;
    ma[1] = 32'h111; ma[3] = 32'h333;
    push(1, slv_data(32'h111), 1'b0);
    push(3, slv_data(32'h333), 1'b0);
    tick();
    rst = 1'b0;
    drain(30);

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    // slave never answers: abort after four busy cycles
    ma[0] = 32'h80; swait = 1000; busy_cnt = 0;
    push(0, 32'hDEAD_BEEF, 1'b1);
    m_req = 4'b0001;
    drain(30);
    chk("tmo_busy_cycles", 32'(busy_cnt), 32'd4);
    // grant on the last allowed cycle wins over the abort
    swait = 3; busy_cnt = 0;
    push(0, slv_data(32'h80), 1'b0);
    m_req = 4'b0001;
    drain(30);
    chk("coll_busy_cycles", 32'(busy_cnt), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one bus master port (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for bus_gnt (used only with the timeout feature compiled in).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m_req  input  NUM_REQ  per-requester request; held until the matching m_gnt bit.
REQ-006 m_rw  input  NUM_REQ  per-requester direction: 0 = read, 1 = write.
REQ-007 m_addr  input  NUM_REQ*32  per-requester address; slice i = [32*i+31:32*i].
REQ-008 m_wdata  input  NUM_REQ*32  per-requester write data, same slicing.
REQ-009 m_gnt  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-010 m_rdata  output  32  read data, shared by all requesters, valid while m_gnt is high.
REQ-011 m_err  output  1  completion was a timeout abort, valid while m_gnt is high.
REQ-012 bus_req, bus_rw  output  1 each  to the shared bus slave.
REQ-013 bus_addr, bus_wdata  output  32 each  to the shared bus slave.
REQ-014 bus_gnt  input  1  slave completion strobe; bus_rdata is valid in the same cycle.
REQ-015 bus_rdata  input  32  slave read data.

Function
REQ-016 States SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE with any m_req bit set: SHALL pick the winner round-robin, searching from last_owner+1 with wrap-around. SHALL register owner, addr, wdata and rw. SHALL go to BUSY.
REQ-018 BUSY: bus_req SHALL be 1. bus_addr, bus_wdata and bus_rw SHALL be the registered values and stable. Latency is 1 cycle from m_req to bus_req.
REQ-019 BUSY with bus_gnt=1: SHALL capture bus_rdata into m_rdata, set last_owner=owner and go to DONE. bus_req SHALL drop in the next cycle.
REQ-020 DONE: m_gnt[owner] SHALL be 1 for exactly one cycle, all other m_gnt bits 0. The next state SHALL be IDLE.
REQ-021 Requests present in the IDLE cycle that follows DONE SHALL be arbitrated normally. Minimum spacing is 3 cycles per transfer.
REQ-022 m_req changes during BUSY or DONE SHALL NOT affect the transfer in flight. A requester dropping m_req mid-transfer still receives m_gnt.
REQ-023 bus_gnt in IDLE or DONE SHALL be ignored.
REQ-024 m_rdata SHALL hold its last captured value until the next capture. For writes, m_rdata SHALL be the value on bus_rdata at the bus_gnt cycle.
REQ-025 Without a timeout, m_err SHALL be 0 in every cycle.

Reset
REQ-026 On rst assertion, the block SHALL immediately (asynchronously) set: state=IDLE, last_owner=NUM_REQ-1 (requester 0 wins first), bus_req=0, bus_rw=0, bus_addr=0, bus_wdata=0, m_gnt=0, m_rdata=0, m_err=0, timeout counter=0.
REQ-027 Reset during BUSY SHALL abandon the transfer with no m_gnt pulse. The first arbitration after reset SHALL follow REQ-026 priority.

Configuration
REQ-028 Macro BUS_RR_ARBITER_TIMEOUT_EN defined: a counter SHALL clear on BUSY entry and increment each BUSY cycle without bus_gnt.
REQ-029 When that count reaches TIMEOUT, the transfer SHALL abort: bus_req drops, DONE is entered with m_err=1 and m_rdata=32'hDEAD_BEEF, and last_owner advances.
REQ-030 bus_gnt in the same cycle as the timeout SHALL win: normal completion with m_err=0.
REQ-031 Macro undefined: no counter SHALL be present, BUSY SHALL wait indefinitely, and m_err SHALL be tied 0.

Verification
REQ-032 Single read: m_req=4'b0010, m_addr[1]=32'h100, m_rw[1]=0, slave gnt 2 cycles after bus_req with rdata 32'hCAFE0001 -> bus_addr=32'h100, bus_rw=0, m_gnt=4'b0010 for 1 cycle, m_rdata=32'hCAFE0001, m_err=0.
REQ-033 Fairness: m_req=4'b1111 held, zero-wait slave -> grant order 0,1,2,3,0,... and each grant 3 cycles apart.
REQ-034 Write passthrough: requester 2 with rw=1, addr=32'h20, wdata=32'h5A5A5A5A -> bus shows the same values, stable through all of BUSY.
REQ-035 Reset mid-transfer: rst pulsed in BUSY -> bus_req=0 immediately and no m_gnt. After release with m_req=4'b1010, requester 1 wins first.
REQ-036 Timeout (macro defined, TIMEOUT=4): slave never grants -> bus_req held 4 cycles, then m_gnt pulse with m_err=1 and m_rdata=32'hDEAD_BEEF.
REQ-037 Timeout collision (macro defined, TIMEOUT=4): bus_gnt arrives in the 4th BUSY cycle -> m_err=0 and the captured rdata is returned.
